controlador_lcd: RTL and testbench



---
 rtl/pkg_lcd.sv | 72 +++++++
 rtl/lcd_escritor_byte.sv | 87 ++++++++
 rtl/controlador_lcd.sv | 201 ++++++++++++++++++++
 tb/tb_controlador_lcd.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_lcd.sv
// Shared types, LCD command/ASCII constants and helper functions for controlador_lcd.
package pkg_lcd;

    typedef enum logic [2:0] {
        INIT_ESPERA,
        INIT_CMD,
        OCIOSO,
        CONVERTE,
        ESCREVE,
        FIM
    } estado_t;

    typedef enum logic [1:0] {
        B_OCIOSO,
        B_SETUP,
        B_PULSO,
        B_ESPERA
    } estado_byte_t;

    localparam logic [7:0] LCD_CMD_FUNC  = 8'h38;
    localparam logic [7:0] LCD_CMD_ON    = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY = 8'h06;
    localparam logic [7:0] LCD_LINHA1    = 8'h80;
    localparam logic [7:0] LCD_LINHA2    = 8'hC0;

    localparam logic [7:0] ASCII_ESPACO = 8'h20;
    localparam logic [7:0] ASCII_MAIS   = 8'h2B;
    localparam logic [7:0] ASCII_MENOS  = 8'h2D;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_A      = 8'h41;
    localparam logic [7:0] ASCII_R      = 8'h52;

    localparam int N_INIT = 4;
    localparam int N_MSG  = 16;
    localparam int N_CONV = 16;

    // Four ASCII characters packed MSB first.
    function automatic logic [31:0] mnemonico(input logic [2:0] op);
        logic [31:0] m;
        case (op)
            3'd0:    m = "LOAD";
            3'd1:    m = "ADD ";
            3'd2:    m = "ADDI";
            3'd3:    m = "SUB ";
            3'd4:    m = "SUBI";
            3'd5:    m = "MUL ";
            3'd6:    m = "CLR ";
            default: m = "DPL ";
        endcase
        return m;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return ASCII_ZERO + {4'd0, n};
        else
            return ASCII_A + {4'd0, n} - 8'd10;
    endfunction

    // One double-dabble step: {5 BCD digits, 16-bit binary} -> adjust digits >= 5, shift left.
    function automatic logic [35:0] dabble_passo(input logic [35:0] dd);
        logic [35:0] t;
        t = dd;
        for (int k = 0; k < 5; k++) begin
            if (t[16+4*k +: 4] >= 4'd5)
                t[16+4*k +: 4] = t[16+4*k +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction

endpackage

// File: rtl/lcd_escritor_byte.sv
// Writes one byte to the HD44780 bus: set rs/data, pulse lcd_e, then wait T_CMD or T_CLEAR.
module lcd_escritor_byte
    import pkg_lcd::*;
#(
    parameter int T_PULSE = 25,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dado,
    input  logic       rs,
    input  logic       longo,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    localparam int T_MAX_CW = (T_CMD > T_PULSE) ? T_CMD : T_PULSE;
    localparam int T_MAX    = (T_CLEAR > T_MAX_CW) ? T_CLEAR : T_MAX_CW;
    localparam int CW       = $clog2(T_MAX + 1);

    estado_byte_t  estado;
    logic [CW-1:0] cnt;
    logic [CW-1:0] limite;
    logic          longo_r;

    // start is sampled when idle or in the cycle done is high (back-to-back bytes);
    // done is high only during the last wait cycle of the current byte.
    assign limite = longo_r ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
    assign done   = (estado == B_ESPERA) && (cnt == limite);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= B_OCIOSO;
            cnt      <= '0;
            longo_r  <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (estado)
                B_OCIOSO: begin
                    if (start) begin
                        lcd_rs   <= rs;
                        lcd_data <= dado;
                        longo_r  <= longo;
                        estado   <= B_SETUP;
                    end
                end
                B_SETUP: begin
                    lcd_e  <= 1'b1;
                    cnt    <= '0;
                    estado <= B_PULSO;
                end
                B_PULSO: begin
                    if (cnt == CW'(T_PULSE - 1)) begin
                        lcd_e  <= 1'b0;
                        cnt    <= '0;
                        estado <= B_ESPERA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                B_ESPERA: begin
                    if (done) begin
                        cnt <= '0;
                        if (start) begin
                            lcd_rs   <= rs;
                            lcd_data <= dado;
                            longo_r  <= longo;
                            estado   <= B_SETUP;
                        end else begin
                            estado <= B_OCIOSO;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: estado <= B_OCIOSO;
            endcase
        end
    end

endmodule

// File: rtl/controlador_lcd.sv
// 16x2 LCD output stage: init, binary-to-BCD and message write of opcode/register/result.
// Define LCD_ZERO_SUPPRESS_EN to blank leading zero digits of the result.
module controlador_lcd
    import pkg_lcd::*;
#(
    parameter int T_POWERUP = 750000,
    parameter int T_PULSE   = 25,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicio,
    input  logic [2:0]  instrucao,
    input  logic [3:0]  reg_idx,
    input  logic [15:0] valor,
    output logic        pronto,
    output logic        concluido,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data
);

    localparam int PW = $clog2(T_POWERUP + 1);

    estado_t       estado;
    logic [PW-1:0] cnt_pw;
    logic [3:0]    cnt_conv;
    logic [4:0]    idx;
    logic [2:0]    op_r;
    logic [3:0]    reg_r;
    logic          neg_r;
    logic [35:0]   dd;

    logic [15:0]   mag;
    logic [31:0]   mn;
    logic          byte_start;
    logic          byte_done;
    logic          byte_rs;
    logic          byte_longo;
    logic [7:0]    byte_dado;

    assign lcd_rw = 1'b0;
    assign mag    = valor[15] ? (~valor + 16'd1) : valor;
    assign mn     = mnemonico(op_r);

    // Digit k (0 = most significant) of the 5-digit BCD result as ASCII.
    function automatic logic [7:0] digito_ascii(input logic [19:0] bcd, input int k);
`ifdef LCD_ZERO_SUPPRESS_EN
        logic lider;
        lider = (k < 4);
        for (int j = 0; j < 5; j++) begin
            if (j <= k && bcd[19-4*j -: 4] != 4'd0)
                lider = 1'b0;
        end
        if (lider)
            return ASCII_ESPACO;
`endif
        return ASCII_ZERO + {4'd0, bcd[19-4*k -: 4]};
    endfunction

    // idx always names the next byte to launch; it is 0 while the first byte is being launched.
    always_comb begin
        byte_dado = 8'h00;
        byte_rs   = 1'b0;
        if (estado == INIT_ESPERA || estado == INIT_CMD) begin
            case (idx[1:0])
                2'd0:    byte_dado = LCD_CMD_FUNC;
                2'd1:    byte_dado = LCD_CMD_ON;
                2'd2:    byte_dado = LCD_CMD_CLEAR;
                default: byte_dado = LCD_CMD_ENTRY;
            endcase
        end else begin
            byte_rs = 1'b1;
            case (idx[3:0])
                4'd0:  begin byte_dado = LCD_CMD_CLEAR; byte_rs = 1'b0; end
                4'd1:  begin byte_dado = LCD_LINHA1;    byte_rs = 1'b0; end
                4'd2:  byte_dado = mn[31:24];
                4'd3:  byte_dado = mn[23:16];
                4'd4:  byte_dado = mn[15:8];
                4'd5:  byte_dado = mn[7:0];
                4'd6:  byte_dado = ASCII_ESPACO;
                4'd7:  byte_dado = ASCII_R;
                4'd8:  byte_dado = hex_ascii(reg_r);
                4'd9:  begin byte_dado = LCD_LINHA2;    byte_rs = 1'b0; end
                4'd10: byte_dado = neg_r ? ASCII_MENOS : ASCII_MAIS;
                4'd11: byte_dado = digito_ascii(dd[35:16], 0);
                4'd12: byte_dado = digito_ascii(dd[35:16], 1);
                4'd13: byte_dado = digito_ascii(dd[35:16], 2);
                4'd14: byte_dado = digito_ascii(dd[35:16], 3);
                default: byte_dado = digito_ascii(dd[35:16], 4);
            endcase
        end
    end

    assign byte_longo = !byte_rs && (byte_dado == LCD_CMD_CLEAR);

    // The first byte of each burst is launched in the last cycle of the preceding wait/convert
    // phase so the byte train follows without a gap.
    always_comb begin
        byte_start = 1'b0;
        case (estado)
            INIT_ESPERA: byte_start = (cnt_pw == PW'(T_POWERUP - 1));
            INIT_CMD:    byte_start = byte_done && (idx != 5'(N_INIT));
            CONVERTE:    byte_start = (cnt_conv == 4'(N_CONV - 1));
            ESCREVE:     byte_start = byte_done && (idx != 5'(N_MSG));
            default:     byte_start = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= INIT_ESPERA;
            cnt_pw    <= '0;
            cnt_conv  <= '0;
            idx       <= '0;
            op_r      <= '0;
            reg_r     <= '0;
            neg_r     <= 1'b0;
            dd        <= '0;
            pronto    <= 1'b0;
            concluido <= 1'b0;
        end else begin
            case (estado)
                INIT_ESPERA: begin
                    if (byte_start) begin
                        idx    <= 5'd1;
                        estado <= INIT_CMD;
                    end else begin
                        cnt_pw <= cnt_pw + PW'(1);
                    end
                end
                INIT_CMD: begin
                    if (byte_done) begin
                        if (idx == 5'(N_INIT)) begin
                            pronto <= 1'b1;
                            estado <= OCIOSO;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                OCIOSO: begin
                    if (inicio) begin
                        op_r     <= instrucao;
                        reg_r    <= reg_idx;
                        neg_r    <= valor[15];
                        dd       <= {20'd0, mag};
                        cnt_conv <= '0;
                        idx      <= '0;
                        pronto   <= 1'b0;
                        estado   <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    dd       <= dabble_passo(dd);
                    cnt_conv <= cnt_conv + 4'd1;
                    if (byte_start) begin
                        idx    <= 5'd1;
                        estado <= ESCREVE;
                    end
                end
                ESCREVE: begin
                    if (byte_done) begin
                        if (idx == 5'(N_MSG)) begin
                            concluido <= 1'b1;
                            pronto    <= 1'b1;
                            estado    <= FIM;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                FIM: begin
                    concluido <= 1'b0;
                    estado    <= OCIOSO;
                end
                default: estado <= INIT_ESPERA;
            endcase
        end
    end

    lcd_escritor_byte #(
        .T_PULSE (T_PULSE),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR)
    ) u_escritor (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (byte_start),
        .dado     (byte_dado),
        .rs       (byte_rs),
        .longo    (byte_longo),
        .done     (byte_done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

endmodule

// File: tb/tb_controlador_lcd.sv
// Scoreboard bench for controlador_lcd with a message-level reference model.
module tb_controlador_lcd;

    localparam int T_POWERUP = 20;
    localparam int T_PULSE   = 2;
    localparam int T_CMD     = 4;
    localparam int T_CLEAR   = 8;
    // inicio cycle + 16 convert cycles + 16 byte cycles; concluido appears right after.
    localparam int LAT = 1 + 16 + (1 + T_PULSE + T_CLEAR) + 15 * (1 + T_PULSE + T_CMD);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio;
    logic [2:0]  instrucao;
    logic [3:0]  reg_idx;
    logic [15:0] valor;
    logic        pronto, concluido, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]  lcd_data;

    controlador_lcd #(
        .T_POWERUP (T_POWERUP),
        .T_PULSE   (T_PULSE),
        .T_CMD     (T_CMD),
        .T_CLEAR   (T_CLEAR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inicio    (inicio),
        .instrucao (instrucao),
        .reg_idx   (reg_idx),
        .valor     (valor),
        .pronto    (pronto),
        .concluido (concluido),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_data  (lcd_data)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    // exp item: {expected low-gap before rise (0 = unchecked), rs, data}
    logic [16:0] exp_q[$];
    int          lat_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          bytes_seen = 0;

    string mn_tab [8] = '{"LOAD", "ADD ", "ADDI", "SUB ", "SUBI", "MUL ", "CLR ", "DPL "};
    int    divs   [5] = '{10000, 1000, 100, 10, 1};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_byte(input int gap, input logic rs, input logic [7:0] d);
        exp_q.push_back({8'(gap), rs, d});
    endtask

    task automatic push_init();
        push_byte(0,           1'b0, 8'h38);
        push_byte(T_CMD + 1,   1'b0, 8'h0C);
        push_byte(T_CMD + 1,   1'b0, 8'h01);
        push_byte(T_CLEAR + 1, 1'b0, 8'h06);
    endtask

    // Reference model: builds the 16 bytes of a message directly from the display rules.
    task automatic push_msg(input logic [2:0] ins, input logic [3:0] r, input logic [15:0] v);
        int     m, d;
        bit     lead;
        string  s;
        m = v[15] ? (65536 - int'(v)) : int'(v);
        s = mn_tab[ins];
        push_byte(0,           1'b0, 8'h01);
        push_byte(T_CLEAR + 1, 1'b0, 8'h80);
        for (int k = 0; k < 4; k++) push_byte(T_CMD + 1, 1'b1, s[k]);
        push_byte(T_CMD + 1, 1'b1, " ");
        push_byte(T_CMD + 1, 1'b1, "R");
        push_byte(T_CMD + 1, 1'b1, (r < 10) ? 8'(48 + r) : 8'(55 + r));
        push_byte(T_CMD + 1, 1'b0, 8'hC0);
        push_byte(T_CMD + 1, 1'b1, v[15] ? "-" : "+");
        lead = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d = (m / divs[k]) % 10;
            if (d != 0 || k == 4) lead = 1'b0;
`ifdef LCD_ZERO_SUPPRESS_EN
            if (lead) push_byte(T_CMD + 1, 1'b1, 8'h20);
            else      push_byte(T_CMD + 1, 1'b1, 8'(48 + d));
`else
            push_byte(T_CMD + 1, 1'b1, 8'(48 + d));
`endif
        end
    endtask

    // ---------------- monitor ----------------
    logic       prev_e = 1'b0, prev_c = 1'b0, cur_rs;
    logic [7:0] cur_data;
    int         hi = 0, lo = 0;
    logic [16:0] item;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_e = 1'b0;
            prev_c = 1'b0;
            hi = 0;
            lo = 0;
        end else begin
            if (lcd_e && !prev_e) begin
                hi = 1;
                bytes_seen++;
                cur_rs   = lcd_rs;
                cur_data = lcd_data;
                check("rw_low", {31'd0, lcd_rw}, 32'd0);
                check("pronto_busy", {31'd0, pronto}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL byte_unexpected: got rs=%0d data=0x%02h, none expected", lcd_rs, lcd_data);
                end else begin
                    item = exp_q.pop_front();
                    check("byte_rs_data", {23'd0, lcd_rs, lcd_data}, {23'd0, item[8:0]});
                    if (item[16:9] != 8'd0)
                        check("byte_gap", lo, {24'd0, item[16:9]});
                end
            end else if (lcd_e) begin
                hi++;
            end else if (prev_e) begin
                check("pulse_width", hi, T_PULSE);
                check("hold_rs_data", {23'd0, lcd_rs, lcd_data}, {23'd0, cur_rs, cur_data});
                lo = 1;
            end else begin
                lo++;
            end

            if (concluido && prev_c) begin
                n_tests++;
                n_fail++;
                $display("FAIL concluido_width: got high two cycles, required one");
            end else if (concluido) begin
                check("pronto_in_fim", {31'd0, pronto}, 32'd1);
                if (lat_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL concluido_unexpected: got pulse at cycle %0d, none expected", cyc);
                end else begin
                    check("concluido_cycle", cyc, lat_q.pop_front());
                end
            end
            prev_e = lcd_e;
            prev_c = concluido;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(pronto && !concluido) && n < budget);
        check({nm, "_idle"}, {31'd0, pronto && !concluido}, 32'd1);
    endtask

    // Called 1 time unit after a posedge; inicio is sampled on the next edge.
    task automatic send(input logic [2:0] ins, input logic [3:0] r, input logic [15:0] v, input bit accept);
        instrucao = ins;
        reg_idx   = r;
        valor     = v;
        inicio    = 1'b1;
        if (accept) begin
            push_msg(ins, r, v);
            lat_q.push_back(cyc + LAT);
        end
        @(posedge clk); #1;
        inicio = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int base;
        rst_n = 1'b0;
        inicio = 1'b0;
        instrucao = '0;
        reg_idx = '0;
        valor = '0;
        repeat (2) @(negedge clk);
        check("rst_pronto",    {31'd0, pronto},    32'd0);
        check("rst_concluido", {31'd0, concluido}, 32'd0);
        check("rst_lcd_e",     {31'd0, lcd_e},     32'd0);
        check("rst_lcd_rs",    {31'd0, lcd_rs},    32'd0);
        check("rst_lcd_rw",    {31'd0, lcd_rw},    32'd0);
        check("rst_lcd_data",  {24'd0, lcd_data},  32'd0);
        push_init();
        rst_n = 1'b1;
        wait_idle(400, "init");
        check("init_bytes_left", exp_q.size(), 0);

        send(3'd1, 4'd3, 16'd42, 1'b1);
        wait_idle(300, "add_r3");
        send(3'd5, 4'hF, 16'h8000, 1'b1);
        wait_idle(300, "mul_rf");
        send(3'd6, 4'd0, 16'd0, 1'b1);
        wait_idle(300, "zero");
        send(3'd2, 4'd10, 16'd32767, 1'b1);
        wait_idle(300, "max");

        // Extra inicio mid-message must be dropped.
        send(3'd0, 4'd10, 16'd1234, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        send(3'd4, 4'd2, 16'd999, 1'b0);
        wait_idle(300, "ignored_inicio");
        check("mid_msg_bytes_left", exp_q.size(), 0);

        for (int i = 0; i < 6; i++) begin
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom), 1'b1);
            wait_idle(300, "random");
        end

        // Reset while byte 9 is strobing.
        base = bytes_seen;
        send(3'd2, 4'd9, 16'hFFF9, 1'b1);
        n = 0;
        while (bytes_seen < base + 10 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        check("reach_byte9", bytes_seen - base, 10);
        check("byte9_e_high", {31'd0, lcd_e}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_e_drop", {31'd0, lcd_e}, 32'd0);
        check("reset_pronto", {31'd0, pronto}, 32'd0);
        exp_q.delete();
        lat_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        rst_n = 1'b1;
        wait_idle(400, "reinit");
        check("reinit_bytes_left", exp_q.size(), 0);

        // inicio in the FIM cycle is ignored, one cycle later it is accepted.
        send(3'd3, 4'd1, 16'd100, 1'b1);
        n = 0;
        while (!concluido && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("fim_seen", {31'd0, concluido}, 32'd1);
        instrucao = 3'd7;
        reg_idx   = 4'd5;
        valor     = 16'd1234;
        inicio    = 1'b1;
        @(posedge clk); #1;
        valor = 16'hFFFF;
        push_msg(3'd7, 4'd5, 16'hFFFF);
        lat_q.push_back(cyc + LAT);
        @(posedge clk); #1;
        inicio = 1'b0;
        wait_idle(300, "after_fim");

        repeat (5) @(posedge clk);
        check("final_bytes_left", exp_q.size(), 0);
        check("final_concluido_left", lat_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
